mul_ab_splitter: RTL

MUL_AB_SPLITTER -- requirements
Module: mul_ab_splitter

---
 rtl/mul_ab_splitter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mul_ab_splitter.sv
// Splits a packed {b, a} pair stream into two independently-drained operand streams.
// It also tracks vector boundaries and flags vectors whose TLAST and reg_len disagree.
module mul_ab_splitter #(
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_TVALID,
    output logic             in_TREADY,
    input  logic [63:0]      in_TDATA,
    input  logic             in_TLAST,
    output logic             a_TVALID,
    input  logic             a_TREADY,
    output logic [31:0]      a_TDATA,
    output logic             b_TVALID,
    input  logic             b_TREADY,
    output logic [31:0]      b_TDATA,
    input  logic [LEN_W-1:0] reg_len,
    input  logic             reg_clear,
    output logic             vec_done_o,
    output logic             err_len_o,
    output logic [15:0]      vec_cnt_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lane 0 carries operand a, lane 1 carries operand b.
    logic [1:0][31:0] lane_din;
    logic [1:0][31:0] lane_head;
    logic [1:0]       lane_full;
    logic [1:0]       lane_valid;
    logic [1:0]       lane_pop;
    logic             push;

    assign lane_din  = {in_TDATA[63:32], in_TDATA[31:0]};
    assign lane_pop  = {b_TVALID & b_TREADY, a_TVALID & a_TREADY};
    assign in_TREADY = ap_rst_n & ~reg_clear & ~(|lane_full);
    assign push      = in_TVALID & in_TREADY;

    assign a_TVALID = lane_valid[0];
    assign a_TDATA  = lane_head[0];
    assign b_TVALID = lane_valid[1];
    assign b_TDATA  = lane_head[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [31:0]      mem [FIFO_DEPTH];
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [CNT_W-1:0] count_reg;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                    for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
                end else if (reg_clear) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        mem[wr_ptr_reg] <= lane_din[gi];
                        wr_ptr_reg      <= ptr_inc(wr_ptr_reg);
                    end
                    if (lane_pop[gi]) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    count_reg <= count_reg + CNT_W'(push) - CNT_W'(lane_pop[gi]);
                end
            end

            // Head comes straight from storage, so there is no input-to-output path.
            assign lane_valid[gi] = (count_reg != '0);
            assign lane_full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));
            assign lane_head[gi]  = mem[rd_ptr_reg];
        end
    endgenerate

    logic [LEN_W-1:0] idx_reg;
    logic             at_len;
    logic             vec_end;

    assign at_len  = (idx_reg == reg_len);
    assign vec_end = in_TLAST | at_len;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            idx_reg    <= '0;
            vec_done_o <= 1'b0;
            err_len_o  <= 1'b0;
            vec_cnt_o  <= '0;
        end else if (reg_clear) begin
            idx_reg    <= '0;
            vec_done_o <= 1'b0;
            err_len_o  <= 1'b0;
            vec_cnt_o  <= '0;
        end else begin
            vec_done_o <= push & vec_end;
            if (push) begin
                if (vec_end) begin
                    idx_reg   <= '0;
                    vec_cnt_o <= vec_cnt_o + 16'd1;
                    // TLAST and the programmed length must agree on where the vector ends.
                    if (in_TLAST != at_len) err_len_o <= 1'b1;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end
endmodule
